// File: rtl/orb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : orb_ram_arbiter
//  Purpose  : Shares one double-buffered single-port orbital frame RAM between
//             two packer write channels and one telemetry reader, using
//             round-robin arbitration and a drain-then-swap page flip.
//  Revision : 1.0  initial release
// ============================================================================
module orb_ram_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 12,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WE1,
    input  logic [AW-1:0] WrAddr1,
    input  logic [DW-1:0] orbWord1,
    input  logic          WE2,
    input  logic [AW-1:0] WrAddr2,
    input  logic [DW-1:0] orbWord2,
    input  logic          rdReq,
    input  logic [AW-1:0] rdAddr,
    output logic [DW-1:0] rdData,
    output logic          rdValid,
    output logic          rdBusy,
    input  logic          swapReq,
    output logic          swapDone,
    output logic          SW,
    output logic [1:0]    ovf,
    output logic [AW:0]   ramAddr,
    output logic [DW-1:0] ramWrData,
    output logic          ramWE,
    input  logic [DW-1:0] ramRdData
);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_SWAP  = 2'd2;

    logic [1:0]        r_state;
    logic              r_wrPage;
    logic              r_we1D, r_we2D;
    logic              r_pend1, r_pend2, r_pendR;
    logic [AW-1:0]     r_addr1, r_addr2, r_rdAddr;
    logic [DW-1:0]     r_data1, r_data2;
    logic [1:0]        r_rrPtr;
    logic [RD_LAT-1:0] r_rdPipe;

    logic       w_edge1, w_edge2;
    logic [2:0] w_req;
    logic [1:0] w_gntId;
    logic       w_gntAny;
    logic       w_gnt1, w_gnt2, w_gntR;

    assign w_edge1 = WE1 & ~r_we1D;
    assign w_edge2 = WE2 & ~r_we2D;
    assign w_req   = {r_pendR, r_pend2, r_pend1};
    assign w_gnt1  = w_gntAny && (w_gntId == 2'd0);
    assign w_gnt2  = w_gntAny && (w_gntId == 2'd1);
    assign w_gntR  = w_gntAny && (w_gntId == 2'd2);
    assign rdBusy  = r_pendR | (|r_rdPipe);
    assign SW      = r_wrPage;

    // Round-robin pick starting at rrPtr; the swap cycle owns the RAM exclusively
    always_comb begin
        w_gntId  = r_rrPtr;
        w_gntAny = 1'b0;
        if (r_state != c_SWAP) begin
            case (r_rrPtr)
                2'd1: begin
                    if (w_req[1])      begin w_gntId = 2'd1; w_gntAny = 1'b1; end
                    else if (w_req[2]) begin w_gntId = 2'd2; w_gntAny = 1'b1; end
                    else if (w_req[0]) begin w_gntId = 2'd0; w_gntAny = 1'b1; end
                end
                2'd2: begin
                    if (w_req[2])      begin w_gntId = 2'd2; w_gntAny = 1'b1; end
                    else if (w_req[0]) begin w_gntId = 2'd0; w_gntAny = 1'b1; end
                    else if (w_req[1]) begin w_gntId = 2'd1; w_gntAny = 1'b1; end
                end
                default: begin
                    if (w_req[0])      begin w_gntId = 2'd0; w_gntAny = 1'b1; end
                    else if (w_req[1]) begin w_gntId = 2'd1; w_gntAny = 1'b1; end
                    else if (w_req[2]) begin w_gntId = 2'd2; w_gntAny = 1'b1; end
                end
            endcase
        end
    end

    // Write-channel capture: a new edge overwrites the slot, flagging overrun if it was still unserved
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we1D  <= 1'b0;
            r_we2D  <= 1'b0;
            r_pend1 <= 1'b0;
            r_pend2 <= 1'b0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            ovf     <= 2'b00;
        end else begin
            r_we1D <= WE1;
            r_we2D <= WE2;
            if (w_edge1) begin
                r_pend1 <= 1'b1;
                r_addr1 <= WrAddr1;
                r_data1 <= orbWord1;
                if (r_pend1 && !w_gnt1) ovf[0] <= 1'b1;
            end else if (w_gnt1) begin
                r_pend1 <= 1'b0;
            end
            if (w_edge2) begin
                r_pend2 <= 1'b1;
                r_addr2 <= WrAddr2;
                r_data2 <= orbWord2;
                if (r_pend2 && !w_gnt2) ovf[1] <= 1'b1;
            end else if (w_gnt2) begin
                r_pend2 <= 1'b0;
            end
        end
    end

    // Read request capture and return pipe; data is taken from the RAM RD_LAT cycles after issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pendR  <= 1'b0;
            r_rdAddr <= '0;
            r_rdPipe <= '0;
            rdValid  <= 1'b0;
            rdData   <= '0;
        end else begin
            if (rdReq && !rdBusy) begin
                r_pendR  <= 1'b1;
                r_rdAddr <= rdAddr;
            end else if (w_gntR) begin
                r_pendR <= 1'b0;
            end
            r_rdPipe[0] <= w_gntR;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rdPipe[i] <= r_rdPipe[i-1];
            end
            rdValid <= r_rdPipe[RD_LAT-1];
            if (r_rdPipe[RD_LAT-1]) rdData <= ramRdData;
        end
    end

    // RAM port register: writes go to wrPage, reads to the other page; address holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramWE     <= 1'b0;
            ramAddr   <= '0;
            ramWrData <= '0;
            r_rrPtr   <= 2'd0;
        end else begin
            ramWE <= 1'b0;
            if (w_gnt1) begin
                ramWE     <= 1'b1;
                ramAddr   <= {r_wrPage, r_addr1};
                ramWrData <= r_data1;
            end else if (w_gnt2) begin
                ramWE     <= 1'b1;
                ramAddr   <= {r_wrPage, r_addr2};
                ramWrData <= r_data2;
            end else if (w_gntR) begin
                ramAddr <= {~r_wrPage, r_rdAddr};
            end
            if (w_gntAny) r_rrPtr <= (w_gntId == 2'd2) ? 2'd0 : w_gntId + 2'd1;
        end
    end

    // Page-swap FSM: wait for both write slots to empty, then flip the page for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_RUN;
            r_wrPage <= 1'b0;
            swapDone <= 1'b0;
        end else begin
            swapDone <= 1'b0;
            case (r_state)
                c_RUN: begin
                    if (swapReq) r_state <= c_DRAIN;
                end
                c_DRAIN: begin
                    if (!r_pend1 && !r_pend2 && !w_edge1 && !w_edge2) r_state <= c_SWAP;
                end
                c_SWAP: begin
                    r_wrPage <= ~r_wrPage;
                    swapDone <= 1'b1;
                    r_state  <= c_RUN;
                end
                default: r_state <= c_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_orb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_orb_ram_arbiter
//  Purpose  : Directed vector bench for orb_ram_arbiter (arbitration order,
//             overrun, read return, page swap, reset during drain).
//  Revision : 1.0  initial release
// ============================================================================
module tb_orb_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 12;

    logic          clk, rst;
    logic          WE1, WE2, rdReq, swapReq;
    logic [AW-1:0] WrAddr1, WrAddr2, rdAddr;
    logic [DW-1:0] orbWord1, orbWord2;
    logic [DW-1:0] rdData, ramWrData, ramRdData;
    logic          rdValid, rdBusy, swapDone, SW, ramWE;
    logic [1:0]    ovf;
    logic [AW:0]   ramAddr;

    int errCnt = 0;
    int chkCnt = 0;

    orb_ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .WE1(WE1), .WrAddr1(WrAddr1), .orbWord1(orbWord1),
        .WE2(WE2), .WrAddr2(WrAddr2), .orbWord2(orbWord2),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid), .rdBusy(rdBusy),
        .swapReq(swapReq), .swapDone(swapDone), .SW(SW), .ovf(ovf),
        .ramAddr(ramAddr), .ramWrData(ramWrData), .ramWE(ramWE), .ramRdData(ramRdData)
    );

    // RAM stand-in: read data is a fixed scramble of the presented address
    assign ramRdData = ramAddr ^ 12'h5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we1; logic [10:0] a1; logic [11:0] d1;
        logic          we2; logic [10:0] a2; logic [11:0] d2;
        logic          rq;  logic [10:0] ra; logic        swr;
        logic          eWE; logic [11:0] eAddr; logic [11:0] eWD;
        logic          eV;  logic [11:0] eRD;   logic        eB;
        logic          eSD; logic        eSW;   logic [1:0]  eOvf;
    } vec_t;

    vec_t vecs[30];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // we1 a1 d1 | we2 a2 d2 | rq ra swr || eWE eAddr eWD eV eRD eB eSD eSW eOvf
        vecs[0]  = '{1'b0,11'h000,12'h000, 1'b0,11'h000,12'h000, 1'b0,11'h000,1'b0, 1'b0,12'h000,12'h000,1'b0,12'h000,1'b0,1'b0,1'b0,2'd0};
        vecs[1]  = '{1'b1,11'h004,12'h7F8, 1'b1,11'h010,12'h123, 1'b0,11'h000,1'b0, 1'b0,12'h000,12'h000,1'b0,12'h000,1'b0,1'b0,1'b0,2'd0};
        vecs[2]  = '{1'b1,11'h004,12'h7F8, 1'b1,11'h010,12'h123, 1'b0,11'h000,1'b0, 1'b1,12'h004,12'h7F8,1'b0,12'h000,1'b0,1'b0,1'b0,2'd0};
        vecs[3]  = '{1'b0,11'h004,12'h7F8, 1'b0,11'h010,12'h123, 1'b0,11'h000,1'b0, 1'b1,12'h010,12'h123,1'b0,12'h000,1'b0,1'b0,1'b0,2'd0};
        vecs[4]  = '{1'b0,11'h004,12'h7F8, 1'b0,11'h010,12'h123, 1'b0,11'h000,1'b0, 1'b0,12'h010,12'h123,1'b0,12'h000,1'b0,1'b0,1'b0,2'd0};
        vecs[5]  = '{1'b0,11'h004,12'h7F8, 1'b0,11'h010,12'h123, 1'b1,11'h020,1'b0, 1'b0,12'h010,12'h123,1'b0,12'h000,1'b1,1'b0,1'b0,2'd0};
        vecs[6]  = '{1'b0,11'h004,12'h7F8, 1'b0,11'h010,12'h123, 1'b0,11'h020,1'b0, 1'b0,12'h820,12'h123,1'b0,12'h000,1'b1,1'b0,1'b0,2'd0};
        vecs[7]  = '{1'b0,11'h004,12'h7F8, 1'b0,11'h010,12'h123, 1'b0,11'h020,1'b0, 1'b0,12'h820,12'h123,1'b1,12'hD85,1'b0,1'b0,1'b0,2'd0};
        vecs[8]  = '{1'b1,11'h100,12'h111, 1'b1,11'h200,12'h222, 1'b1,11'h030,1'b0, 1'b0,12'h820,12'h123,1'b0,12'h000,1'b1,1'b0,1'b0,2'd0};
        vecs[9]  = '{1'b0,11'h100,12'h111, 1'b1,11'h200,12'h222, 1'b0,11'h030,1'b0, 1'b1,12'h100,12'h111,1'b0,12'h000,1'b1,1'b0,1'b0,2'd0};
        vecs[10] = '{1'b1,11'h101,12'h333, 1'b0,11'h200,12'h222, 1'b0,11'h030,1'b0, 1'b1,12'h200,12'h222,1'b0,12'h000,1'b1,1'b0,1'b0,2'd0};
        vecs[11] = '{1'b1,11'h101,12'h333, 1'b0,11'h200,12'h222, 1'b0,11'h030,1'b0, 1'b0,12'h830,12'h222,1'b0,12'h000,1'b1,1'b0,1'b0,2'd0};
        vecs[12] = '{1'b0,11'h101,12'h333, 1'b0,11'h200,12'h222, 1'b0,11'h030,1'b0, 1'b1,12'h101,12'h333,1'b1,12'hD95,1'b0,1'b0,1'b0,2'd0};
        vecs[13] = '{1'b0,11'h101,12'h333, 1'b0,11'h200,12'h222, 1'b0,11'h030,1'b0, 1'b0,12'h101,12'h333,1'b0,12'h000,1'b0,1'b0,1'b0,2'd0};
        vecs[14] = '{1'b0,11'h101,12'h333, 1'b1,11'h060,12'h555, 1'b0,11'h030,1'b0, 1'b0,12'h101,12'h333,1'b0,12'h000,1'b0,1'b0,1'b0,2'd0};
        vecs[15] = '{1'b0,11'h101,12'h333, 1'b0,11'h060,12'h555, 1'b0,11'h030,1'b0, 1'b1,12'h060,12'h555,1'b0,12'h000,1'b0,1'b0,1'b0,2'd0};
        vecs[16] = '{1'b1,11'h040,12'h444, 1'b1,11'h061,12'h666, 1'b1,11'h050,1'b0, 1'b0,12'h060,12'h555,1'b0,12'h000,1'b1,1'b0,1'b0,2'd0};
        vecs[17] = '{1'b1,11'h040,12'h444, 1'b0,11'h061,12'h666, 1'b0,11'h050,1'b0, 1'b0,12'h850,12'h555,1'b0,12'h000,1'b1,1'b0,1'b0,2'd0};
        vecs[18] = '{1'b1,11'h040,12'h444, 1'b1,11'h062,12'h777, 1'b0,11'h050,1'b0, 1'b1,12'h040,12'h444,1'b1,12'hDF5,1'b0,1'b0,1'b0,2'd2};
        vecs[19] = '{1'b1,11'h040,12'h444, 1'b1,11'h062,12'h777, 1'b0,11'h050,1'b0, 1'b1,12'h062,12'h777,1'b0,12'h000,1'b0,1'b0,1'b0,2'd2};
        vecs[20] = '{1'b0,11'h040,12'h444, 1'b0,11'h062,12'h777, 1'b0,11'h050,1'b0, 1'b0,12'h062,12'h777,1'b0,12'h000,1'b0,1'b0,1'b0,2'd2};
        vecs[21] = '{1'b0,11'h040,12'h444, 1'b1,11'h070,12'h888, 1'b0,11'h050,1'b1, 1'b0,12'h062,12'h777,1'b0,12'h000,1'b0,1'b0,1'b0,2'd2};
        vecs[22] = '{1'b0,11'h040,12'h444, 1'b1,11'h070,12'h888, 1'b0,11'h050,1'b0, 1'b1,12'h070,12'h888,1'b0,12'h000,1'b0,1'b0,1'b0,2'd2};
        vecs[23] = '{1'b0,11'h040,12'h444, 1'b0,11'h070,12'h888, 1'b0,11'h050,1'b0, 1'b0,12'h070,12'h888,1'b0,12'h000,1'b0,1'b0,1'b0,2'd2};
        vecs[24] = '{1'b0,11'h040,12'h444, 1'b0,11'h070,12'h888, 1'b0,11'h050,1'b0, 1'b0,12'h070,12'h888,1'b0,12'h000,1'b0,1'b1,1'b1,2'd2};
        vecs[25] = '{1'b1,11'h005,12'h999, 1'b0,11'h070,12'h888, 1'b0,11'h050,1'b0, 1'b0,12'h070,12'h888,1'b0,12'h000,1'b0,1'b0,1'b1,2'd2};
        vecs[26] = '{1'b1,11'h005,12'h999, 1'b0,11'h070,12'h888, 1'b1,11'h0AA,1'b0, 1'b1,12'h805,12'h999,1'b0,12'h000,1'b1,1'b0,1'b1,2'd2};
        vecs[27] = '{1'b0,11'h005,12'h999, 1'b0,11'h070,12'h888, 1'b1,11'h0BB,1'b0, 1'b0,12'h0AA,12'h999,1'b0,12'h000,1'b1,1'b0,1'b1,2'd2};
        vecs[28] = '{1'b0,11'h005,12'h999, 1'b0,11'h070,12'h888, 1'b0,11'h0BB,1'b0, 1'b0,12'h0AA,12'h999,1'b1,12'h50F,1'b0,1'b0,1'b1,2'd2};
        vecs[29] = '{1'b0,11'h005,12'h999, 1'b0,11'h070,12'h888, 1'b0,11'h0BB,1'b0, 1'b0,12'h0AA,12'h999,1'b0,12'h000,1'b0,1'b0,1'b1,2'd2};

        rst = 1'b1;
        WE1 = 1'b0; WrAddr1 = '0; orbWord1 = '0;
        WE2 = 1'b0; WrAddr2 = '0; orbWord2 = '0;
        rdReq = 1'b0; rdAddr = '0; swapReq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Cycle-by-cycle table: drive on negedge, check just after the rising edge
        for (int i = 0; i < 30; i++) begin
            WE1 = vecs[i].we1; WrAddr1 = vecs[i].a1; orbWord1 = vecs[i].d1;
            WE2 = vecs[i].we2; WrAddr2 = vecs[i].a2; orbWord2 = vecs[i].d2;
            rdReq = vecs[i].rq; rdAddr = vecs[i].ra; swapReq = vecs[i].swr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.ramWE", i),     {15'd0, ramWE},     {15'd0, vecs[i].eWE});
            chk($sformatf("v%0d.ramAddr", i),   {4'd0, ramAddr},    {4'd0, vecs[i].eAddr});
            chk($sformatf("v%0d.ramWrData", i), {4'd0, ramWrData},  {4'd0, vecs[i].eWD});
            chk($sformatf("v%0d.rdValid", i),   {15'd0, rdValid},   {15'd0, vecs[i].eV});
            if (vecs[i].eV)
                chk($sformatf("v%0d.rdData", i), {4'd0, rdData},    {4'd0, vecs[i].eRD});
            chk($sformatf("v%0d.rdBusy", i),    {15'd0, rdBusy},    {15'd0, vecs[i].eB});
            chk($sformatf("v%0d.swapDone", i),  {15'd0, swapDone},  {15'd0, vecs[i].eSD});
            chk($sformatf("v%0d.SW", i),        {15'd0, SW},        {15'd0, vecs[i].eSW});
            chk($sformatf("v%0d.ovf", i),       {14'd0, ovf},       {14'd0, vecs[i].eOvf});
            @(negedge clk);
        end

        // Reset while draining with both channels pending
        WE1 = 1'b1; WrAddr1 = 11'h300; orbWord1 = 12'hABC;
        WE2 = 1'b1; WrAddr2 = 11'h301; orbWord2 = 12'hDEF;
        swapReq = 1'b1;
        @(posedge clk); #1;
        chk("drain.ramWE", {15'd0, ramWE}, 16'd0);
        @(negedge clk);
        swapReq = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst.ramWE", {15'd0, ramWE}, 16'd0);
        chk("rst.SW", {15'd0, SW}, 16'd0);
        chk("rst.ovf", {14'd0, ovf}, 16'd0);
        chk("rst.rdBusy", {15'd0, rdBusy}, 16'd0);
        @(negedge clk);
        WE1 = 1'b0; WE2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post%0d.ramWE", k), {15'd0, ramWE}, 16'd0);
            chk($sformatf("post%0d.SW", k), {15'd0, SW}, 16'd0);
        end

        // FSM must be back in RUN: a fresh swap request completes on the third edge
        @(negedge clk);
        swapReq = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        swapReq = 1'b0;
        begin
            int k;
            k = 1;
            while (k < 8 && !swapDone) begin
                @(posedge clk); #1;
                k++;
            end
            chk("swap.latency", k[15:0], 16'd3);
            chk("swap.SW", {15'd0, SW}, 16'd1);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
`default_nettype wire
